booth_multiplier_main: RTL and testbench
========================================

# booth_multiplier_main

Sequential 8×8 signed (two's-complement) multiplier using radix-2 Booth recoding, implemented as the top-level block `main`. It accepts operands on a single-cycle `valid` strobe, iterates one Booth step per clock, and presents a 16-bit product on `Y`. Its internal state and current Booth bit pair are exported for board-level debug.

## Interface
- Parameters: none. Operand width is fixed at 8 and product width at 16 through package constants.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  one clock; reset is synchronous and active-high.
- `valid`  in  1  start request, level-sampled only in IDLE.
- `A`  in  8  multiplicand, signed.
- `B`  in  8  multiplier, signed.
- `Q_LSB`  out  2  current Booth pair {Q[0], Q₋₁}.
- `Y`  out  16  signed product register.
- `estado`  out  8  one-hot state code: IDLE=8'h01, LOAD=8'h02, CALC=8'h04, DONE=8'h08.

## Operation
- Registers:
  - M (9-bit, sign-extended A)
  - Acc (9-bit)
  - Q (8-bit)
  - Q₋₁ (1-bit)
  - count (3-bit)
  - Y (16-bit)
  - state
- IDLE: if `valid`=1, capture M←sext(A) and Q←B; go to LOAD. Otherwise stay. Operand changes after capture are ignored.
- LOAD: Acc←0, Q₋₁←0, count←0; go to CALC.
- CALC: one Booth step per cycle, selected by {Q[0],Q₋₁}:
  - 01: Acc+M
  - 10: Acc−M
  - 00 / 11: no change
- After the add/subtract, arithmetic-shift-right the 18-bit vector {Acc,Q,Q₋₁} by 1, then count←count+1.
- When count=7, the step's result is also written: Y←{Acc[7:0],Q} of the shifted vector, and state goes to DONE.
- DONE: hold Y. Go to IDLE when `valid`=0; stay in DONE while `valid`=1, so a held `valid` never retriggers.
- The 9-bit accumulator makes −128×−128 correct. All arithmetic is modulo 2⁹ inside Acc.
- `Q_LSB` is driven directly from registers {Q[0],Q₋₁}.
- `Y` changes only on completion or reset. The previous product stays visible during a new computation.

## Timing
- Reset, at the first rising edge with `rst`=1: state=IDLE (`estado`=8'h01), Y=0, `Q_LSB`=0, Acc=0, Q=0, M=0, count=0. `rst` overrides all other activity, including mid-CALC; a partial result is never written to Y.
- With `valid` sampled high at edge k (in IDLE):
  - LOAD during cycle k→k+1
  - CALC over edges k+2…k+9
  - Y valid and `estado`=8'h08 after edge k+9
- Latency is 9 clocks from the sampling edge. The earliest new request is accepted 1 cycle after DONE sees `valid`=0.
- `valid` asserted in LOAD or CALC is ignored.

## Structure
- Package `booth_pkg`:
  - `localparam N=8`, `localparam PW=2*N`
  - `typedef enum logic [7:0] state_t` holding the one-hot codes above
- Optional sub-module `booth_step` (purely combinational): inputs Acc, Q, Q₋₁, M; outputs the next Acc, Q, Q₋₁ after add/sub and arithmetic shift.
- `main` contains the FSM, the registers, and the `booth_step` instance.

## Test plan
- Reset 2 cycles, then A=4, B=2, `valid`=1 for 1 cycle → Y=16'h0008 at edge k+9, `estado`=8'h08; `estado`=8'h01 the cycle after `valid` is low.
- A=−3 (8'hFD), B=5 → Y=16'hFFF1. A=0, B=8'h7F → Y=0.
- A=−128, B=−128 → Y=16'h4000. A=127, B=−128 → Y=16'hC080.
- `valid` held high for 20 cycles with A=3, B=3 → exactly one computation, Y=9, FSM parked in DONE until `valid` drops.
- Assert `rst` during CALC (edge k+5) → `estado`=8'h01, Y=0, `Q_LSB`=0; a later request computes correctly.
- Check the `Q_LSB` trace for B=8'b0000_0110, Q₋₁=0 over the CALC cycles → sequence 00,10,11,01,00,00,00,00.

Source files
------------

// File: rtl/booth_multiplier_main_pkg.sv
// Shared constants, state encoding and small helpers for the radix-2 Booth multiplier.
package booth_pkg;

    localparam int N  = 8;
    localparam int PW = 2 * N;

    // Last value of the step counter; the step taken with this count is the final one.
    localparam logic [2:0] LAST_STEP = 3'(N - 1);

    typedef enum logic [7:0] {
        IDLE = 8'h01,
        LOAD = 8'h02,
        CALC = 8'h04,
        DONE = 8'h08
    } state_t;

    // The accumulator is one bit wider than an operand so that -128 * -128 cannot overflow.
    function automatic logic [N:0] sext_operand(input logic [N-1:0] value);
        return {value[N-1], value};
    endfunction

endpackage

// File: rtl/booth_multiplier_main_step.sv
// One combinational radix-2 Booth step: add/subtract selected by {Q[0],Q-1}, then an arithmetic
// shift right of the whole {Acc,Q,Q-1} vector.
module booth_step
    import booth_pkg::*;
(
    input  logic [N:0]   acc,
    input  logic [N-1:0] q,
    input  logic         q_m1,
    input  logic [N:0]   m,
    output logic [N:0]   acc_next,
    output logic [N-1:0] q_next,
    output logic         q_m1_next
);

    logic [N:0] sum;

    always_comb begin
        sum = acc;
        unique case ({q[0], q_m1})
            2'b01:   sum = acc + m;
            2'b10:   sum = acc - m;
            default: sum = acc;
        endcase
    end

    // Sign bit of the accumulator is replicated into the vacated top position.
    always_comb begin
        acc_next  = {sum[N], sum[N:1]};
        q_next    = {sum[0], q[N-1:1]};
        q_m1_next = q[0];
    end

endmodule

// File: rtl/booth_multiplier_main.sv
// Sequential 8x8 signed Booth multiplier: captures operands on valid, performs one Booth step
// per clock and publishes the 16-bit product when all steps are complete.
module booth_multiplier_main
    import booth_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          valid,
    input  logic [N-1:0]  A,
    input  logic [N-1:0]  B,
    output logic [1:0]    Q_LSB,
    output logic [PW-1:0] Y,
    output logic [7:0]    estado
);

    state_t         state_q, state_d;
    logic [N:0]     m_q, m_d;
    logic [N:0]     acc_q, acc_d;
    logic [N-1:0]   q_q, q_d;
    logic           q_m1_q, q_m1_d;
    logic [2:0]     count_q, count_d;
    logic [PW-1:0]  y_q, y_d;

    logic [N:0]     step_acc;
    logic [N-1:0]   step_q;
    logic           step_q_m1;

    booth_step u_step (
        .acc       (acc_q),
        .q         (q_q),
        .q_m1      (q_m1_q),
        .m         (m_q),
        .acc_next  (step_acc),
        .q_next    (step_q),
        .q_m1_next (step_q_m1)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            m_q     <= '0;
            acc_q   <= '0;
            q_q     <= '0;
            q_m1_q  <= 1'b0;
            count_q <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            acc_q   <= acc_d;
            q_q     <= q_d;
            q_m1_q  <= q_m1_d;
            count_q <= count_d;
            y_q     <= y_d;
        end
    end

    // Y is only ever written on the final step, so the previous product remains visible meanwhile.
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        acc_d   = acc_q;
        q_d     = q_q;
        q_m1_d  = q_m1_q;
        count_d = count_q;
        y_d     = y_q;

        unique case (state_q)
            IDLE: begin
                if (valid) begin
                    m_d     = sext_operand(A);
                    q_d     = B;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                acc_d   = '0;
                q_m1_d  = 1'b0;
                count_d = '0;
                state_d = CALC;
            end
            CALC: begin
                acc_d   = step_acc;
                q_d     = step_q;
                q_m1_d  = step_q_m1;
                count_d = count_q + 3'd1;
                if (count_q == LAST_STEP) begin
                    y_d     = {step_acc[N-1:0], step_q};
                    state_d = DONE;
                end
            end
            DONE: begin
                // A held valid parks here so it cannot start a second computation.
                if (!valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Q_LSB  = {q_q[0], q_m1_q};
    assign Y      = y_q;
    assign estado = state_q;

endmodule

// File: tb/tb_booth_multiplier_main.sv
// Self-checking bench for booth_multiplier_main: directed corner products plus random operands
// compared against a plain signed-multiply reference model.
module tb_booth_multiplier_main;

    logic        clk;
    logic        rst;
    logic        valid;
    logic [7:0]  A;
    logic [7:0]  B;
    logic [1:0]  Q_LSB;
    logic [15:0] Y;
    logic [7:0]  estado;

    int vectors     = 0;
    int miscompares = 0;

    // Product the bench expects to see on Y between completions.
    logic [15:0] shownProduct = 16'h0000;

    booth_multiplier_main dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .A      (A),
        .B      (B),
        .Q_LSB  (Q_LSB),
        .Y      (Y),
        .estado (estado)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] refProduct(input logic [7:0] a, input logic [7:0] b);
        int prod;
        prod = int'($signed(a)) * int'($signed(b));
        return prod[15:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Step-i Booth pair is {B[i], B[i-1]} with B[-1]=0, independent of the multiplicand.
    function automatic logic [1:0] refPair(input logic [7:0] b, input int i);
        logic prev;
        prev = (i == 0) ? 1'b0 : b[i-1];
        return {b[i], prev};
    endfunction

    // Runs one full request from IDLE. With noisy set, valid and the operands are scrambled
    // during LOAD/CALC, which the design must ignore.
    task automatic applyStimulus(input logic [7:0] a, input logic [7:0] b, input bit noisy);
        logic [15:0] expected;
        expected = refProduct(a, b);
        @(negedge clk);
        A     = a;
        B     = b;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
        if (noisy) begin
            A = 8'($urandom);
            B = 8'($urandom);
        end
        checkOutput("estado_load", {8'h00, estado}, 16'h0002);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checkOutput("estado_calc", {8'h00, estado}, 16'h0004);
            checkOutput("q_lsb_trace", {14'h0, Q_LSB}, {14'h0, refPair(b, i)});
            checkOutput("y_hold", Y, shownProduct);
            if (noisy && i < 7) begin
                valid = 1'($urandom_range(0, 1));
                A     = 8'($urandom);
                B     = 8'($urandom);
            end else begin
                valid = 1'b0;
            end
        end
        @(negedge clk);
        checkOutput("estado_done", {8'h00, estado}, 16'h0008);
        checkOutput("product", Y, expected);
        shownProduct = expected;
        @(negedge clk);
        checkOutput("estado_idle", {8'h00, estado}, 16'h0001);
        checkOutput("y_after", Y, expected);
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        rst   = 1'b1;
        valid = 1'b0;
        A     = 8'h00;
        B     = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("reset_estado", {8'h00, estado}, 16'h0001);
        checkOutput("reset_y", Y, 16'h0000);
        checkOutput("reset_q_lsb", {14'h0, Q_LSB}, 16'h0000);
        rst = 1'b0;

        applyStimulus(8'd4, 8'd2, 1'b0);
        applyStimulus(8'hFD, 8'd5, 1'b0);
        applyStimulus(8'd0, 8'h7F, 1'b0);
        applyStimulus(8'h80, 8'h80, 1'b0);
        applyStimulus(8'h7F, 8'h80, 1'b0);
        applyStimulus(8'hFF, 8'hFF, 1'b0);
        applyStimulus(8'h80, 8'h7F, 1'b0);
        applyStimulus(8'h5A, 8'b0000_0110, 1'b0);

        // Held valid: exactly one computation, then parked in DONE until valid drops.
        @(negedge clk);
        A     = 8'd3;
        B     = 8'd3;
        valid = 1'b1;
        repeat (20) @(posedge clk);
        @(negedge clk);
        checkOutput("held_estado", {8'h00, estado}, 16'h0008);
        checkOutput("held_product", Y, 16'h0009);
        valid = 1'b0;
        @(negedge clk);
        checkOutput("held_release", {8'h00, estado}, 16'h0001);
        shownProduct = 16'h0009;

        // Reset arriving in the middle of CALC discards the partial result.
        @(negedge clk);
        A     = 8'd100;
        B     = 8'd77;
        valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midreset_estado", {8'h00, estado}, 16'h0001);
        checkOutput("midreset_y", Y, 16'h0000);
        checkOutput("midreset_q_lsb", {14'h0, Q_LSB}, 16'h0000);
        rst = 1'b0;
        shownProduct = 16'h0000;
        applyStimulus(8'hF6, 8'd12, 1'b0);

        for (int n = 0; n < 24; n++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            applyStimulus(ra, rb, n[0]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
